// File: rtl/xor_parity_frame_checker.sv
// Serial parity checker: folds N_BITS data bits into an XOR accumulator, compares
// against the trailing parity bit and holds the result until frame_ack.
module xor_parity_frame_checker #(
    parameter int N_BITS     = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           bit_in,
    input  logic                           bit_valid,
    output logic                           bit_ready,
    output logic [$clog2(N_BITS+1)-1:0]    bit_cnt,
    output logic                           par_out,
    output logic                           err_out,
    output logic                           frame_valid,
    input  logic                           frame_ack
);

    localparam int CNT_W = $clog2(N_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BITS - 1);

    typedef enum logic [1:0] {
        ST_DATA,
        ST_PAR,
        ST_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic             acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             par_q, par_d;
    logic             err_q, err_d;
    logic             fv_q, fv_d;
    logic             xfer;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_DATA;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            err_q   <= 1'b0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
        end
    end

    // Reset is applied in the register process, so a transfer here only needs the state.
    assign xfer = bit_valid && (state_q != ST_HOLD);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        err_d   = err_q;
        fv_d    = fv_q;
        case (state_q)
            ST_DATA: begin
                if (xfer) begin
                    acc_d = acc_q ^ bit_in;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_PAR;
                    end
                end
            end
            ST_PAR: begin
                if (xfer) begin
                    par_d   = acc_q ^ ODD_PARITY;
                    err_d   = acc_q ^ ODD_PARITY ^ bit_in;
                    fv_d    = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (frame_ack) begin
                    fv_d    = 1'b0;
                    acc_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_DATA;
            end
        endcase
    end

    assign bit_ready   = rst_n && (state_q != ST_HOLD);
    assign bit_cnt     = cnt_q;
    assign par_out     = par_q;
    assign err_out     = err_q;
    assign frame_valid = fv_q;

endmodule

// File: doc/xor_parity_frame_checker.md
Name: xor_parity_frame_checker

Overview:
Serial parity stage placed directly downstream of the XOR gate. It consumes a bit stream one bit per handshake and folds each bit into a running XOR accumulator. Each frame is N_BITS data bits followed by one received parity bit. The block reports the computed parity and a mismatch flag, then holds that result until the consumer acknowledges it.

Parameters:
N_BITS, 8, data bits per frame (legal range 1..255)
ODD_PARITY, 0, 0 = even parity, 1 = odd parity (expected parity bit = XOR of data ^ ODD_PARITY)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous reset, active-low
bit_in  input  1  serial data/parity bit
bit_valid  input  1  bit_in is valid this cycle
bit_ready  output  1  block accepts a bit this cycle
bit_cnt  output  $clog2(N_BITS+1)  data bits accepted in current frame
par_out  output  1  computed parity of the frame's data bits (XOR ^ ODD_PARITY)
err_out  output  1  received parity bit differs from par_out
frame_valid  output  1  par_out/err_out hold a completed-frame result
frame_ack  input  1  consumer takes the result

Behaviour:
- One clock. Reset is synchronous and active-low; only a sampled rst_n=0 at a clk edge resets the block.
- Reset values: state=DATA, acc=0, bit_cnt=0, par_out=0, err_out=0, frame_valid=0. bit_ready=0 while rst_n=0.
- Transfer: a bit moves when bit_valid && bit_ready at a rising edge. bit_in is ignored when bit_valid=0 or bit_ready=0.
- FSM states:
  DATA: bit_ready=1. On transfer, acc<=acc^bit_in and bit_cnt<=bit_cnt+1. When the transfer makes bit_cnt reach N_BITS, next state is PAR.
  PAR: bit_ready=1. bit_cnt holds at N_BITS. On transfer:
    - par_out<=acc^ODD_PARITY
    - err_out<=acc^ODD_PARITY^bit_in
    - frame_valid<=1
    - next state is HOLD
  HOLD: bit_ready=0 and frame_valid=1. par_out and err_out are stable. On frame_ack=1:
    - frame_valid<=0, acc<=0, bit_cnt<=0
    - next state is DATA
- Latency: frame_valid rises on the edge that accepts the parity bit, so it is visible the following cycle. No bit is accepted in the ack cycle. The first bit of the next frame can transfer one cycle after the ack edge.
- After ack, par_out and err_out keep their last values until the next frame completes. Only frame_valid qualifies them.
- frame_ack in DATA or PAR has no effect.
- Gaps: bit_valid may drop for any number of cycles in DATA or PAR. State, acc and bit_cnt hold.
- N_BITS=1: the first transfer moves DATA to PAR.
- Reset mid-frame (any state): the partial frame is discarded and all registers return to reset values on that edge. A pending frame_valid is dropped without ack.
- Reset has priority over simultaneous transfer or ack.
- bit_ready, bit_cnt, par_out, err_out and frame_valid are free of combinational paths from bit_in. bit_ready depends only on state and rst_n.

Test Plan:
- Reset then even frame, N_BITS=8, ODD_PARITY=0: send data 1,0,1,1,0,0,1,0 (four 1s) with bit_valid continuously high, then parity 0 -> after 9 transfers frame_valid=1, par_out=0, err_out=0, bit_ready=0; assert frame_ack one cycle -> frame_valid=0, bit_cnt=0, bit_ready=1.
- Parity error: send data 1,1,1,0,0,0,0,0 (three 1s), then parity 0 -> par_out=1, err_out=1, frame_valid=1.
- Odd mode, ODD_PARITY=1: send data 0×8, then parity 1 -> par_out=1, err_out=0. Send data 0×8, then parity 0 -> err_out=1.
- Backpressure and gaps: toggle bit_valid 1/0 every cycle through a frame -> bit_cnt advances only on valid cycles; in HOLD drive bit_valid=1 with bit_in=1 for 5 cycles -> no state, acc or bit_cnt change and results stay stable until frame_ack.
- Reset mid-operation: pull rst_n low for one cycle after 5 data bits, then send a full 8-bit frame with parity -> the result reflects only the post-reset frame and bit_cnt restarts at 0. Repeat with rst_n low during HOLD -> frame_valid=0 next cycle.
- Simultaneous ack and rst_n=0 in HOLD -> reset wins: state=DATA, acc=0, frame_valid=0, par_out=0, err_out=0.
